mult_sweep_driver: RTL and testbench
====================================

MULT_SWEEP_DRIVER -- requirements
Module: mult_sweep_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; pair space is 2^WIDTH x 2^WIDTH.
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles waited for done after start.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port go  input  1  single-cycle request to begin a full operand sweep.
REQ-006 SHALL have port mult_ready  input  1  multiplier DUT idle and able to accept start.
REQ-007 SHALL have port mult_done  input  1  multiplier DUT product valid.
REQ-008 SHALL have port mult_product  input  2*WIDTH  DUT product.
REQ-009 SHALL have port mult_start  output  1  start pulse to DUT.
REQ-010 SHALL have port mult_multiplicand  output  WIDTH  operand A to DUT.
REQ-011 SHALL have port mult_multiplier  output  WIDTH  operand B to DUT.
REQ-012 SHALL have port busy  output  1  sweep in progress.
REQ-013 SHALL have port finished  output  1  sweep complete, sticky until next accepted go.
REQ-014 SHALL have port pair_count  output  2*WIDTH+1  transactions completed (done or timeout).
REQ-015 SHALL have port err_count  output  16  product mismatches, saturating at 16'hFFFF.
REQ-016 SHALL have port timeout_err  output  1  sticky flag, any transaction timed out.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, NEXT, DONE.
REQ-018 IDLE/DONE + go=1 -> ISSUE; operands, pair_count, err_count, timeout_err, finished cleared; go ignored in ISSUE/WAIT/NEXT.
REQ-019 ISSUE + mult_ready=1 -> mult_start registered high for exactly one cycle on the next edge, state -> WAIT; ISSUE + mult_ready=0 -> stay, start low.
REQ-020 mult_multiplicand/mult_multiplier SHALL be registered and stable from ISSUE entry through WAIT exit.
REQ-021 WAIT SHALL start counting the cycle after start; mult_done=1 -> compare mult_product to zero-extended A*B (2*WIDTH bits), increment err_count on mismatch, -> NEXT.
REQ-022 WAIT with TIMEOUT cycles elapsed and no done -> set timeout_err, increment err_count, -> NEXT; done on the same cycle as expiry counts as done.
REQ-023 mult_done outside WAIT SHALL be ignored.
REQ-024 NEXT SHALL increment pair_count, increment multiplier (inner); on multiplier wrap to 0 increment multiplicand (outer); both wrapped -> DONE, else -> ISSUE; one cycle in NEXT.
REQ-025 busy SHALL be 1 in ISSUE, WAIT, NEXT; finished SHALL be 1 in DONE only.
REQ-026 Sweep order SHALL be (0,0),(0,1)...(0,max),(1,0)...(max,max); final pair_count = 2^(2*WIDTH).

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE and zero all outputs and counters, including mid-transaction; no start pulse emitted while reset_n low.
REQ-028 First go SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-029 With MULT_SWEEP_CHECK_EN defined, compare/err_count logic per REQ-021/022 SHALL be compiled in.
REQ-030 Without MULT_SWEEP_CHECK_EN, err_count SHALL be tied 0, no multiplier/comparator synthesized; timeout_err and sequencing unchanged.

Structure
REQ-031 Package mult_sweep_pkg SHALL hold the FSM state enum and default WIDTH/TIMEOUT constants.
REQ-032 Operand stepping (nested wrap counters, last-pair detect) SHALL be sub-module mult_operand_counter.

Verification (WIDTH=2, TIMEOUT=8 unless stated)
REQ-033 Ideal DUT (ready=1, done 3 cycles after start, correct product), go pulse -> 16 start pulses, finished=1, pair_count=16, err_count=0, timeout_err=0.
REQ-034 DUT returns product+1 for pair (3,2) only -> err_count=1 at finish, pair_count=16.
REQ-035 DUT never asserts done for (1,1) -> after 8 WAIT cycles timeout_err=1, err_count=1, sweep continues to (1,2), pair_count=16.
REQ-036 mult_ready held low 20 cycles after go -> mult_start stays 0, state ISSUE, operands (0,0) stable; start issues on edge after ready rises.
REQ-037 reset_n pulsed low during WAIT of pair (2,1) -> busy=0, mult_start=0, all counters 0 immediately; next go restarts at (0,0).
REQ-038 go pulsed during WAIT and in DONE -> ignored in WAIT; in DONE clears finished and restarts sweep with counters zeroed.

Source files
------------

// File: rtl/mult_sweep_pkg.sv
// Shared types and default sizing for the multiplier sweep driver.
package mult_sweep_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mult_sweep_driver_counter.sv
// Nested operand counters: multiplier is the inner digit, multiplicand the outer.
module mult_operand_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_last
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_clr) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_step) begin
      r_b <= r_b + 1'b1;
      if (&r_b)
        r_a <= r_a + 1'b1;
    end
  end

  assign o_a    = r_a;
  assign o_b    = r_b;
  assign o_last = (&r_a) & (&r_b);

endmodule

// File: rtl/mult_sweep_driver.sv
// Exhaustive operand sweep driver for a start/done multiplier.
// Define MULT_SWEEP_CHECK_EN to compile in product checking and err_count.
module mult_sweep_driver
  import mult_sweep_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic                 mult_ready,
  input  logic                 mult_done,
  input  logic [2*WIDTH-1:0]   mult_product,
  output logic                 mult_start,
  output logic [WIDTH-1:0]     mult_multiplicand,
  output logic [WIDTH-1:0]     mult_multiplier,
  output logic                 busy,
  output logic                 finished,
  output logic [2*WIDTH:0]     pair_count,
  output logic [15:0]          err_count,
  output logic                 timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic              r_start;
  logic              r_busy;
  logic              r_fin;
  logic              r_tmo;
  logic [2*WIDTH:0]  r_pc;
  logic [TW-1:0]     r_wcnt;

  logic              w_go_acc;
  logic              w_step;
  logic              w_last;
  logic              w_expire;
  logic              w_cmp;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;

  assign w_go_acc = go & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_step   = (r_state == ST_NEXT);
  assign w_cmp    = (r_state == ST_WAIT) & mult_done;
  assign w_expire = (r_state == ST_WAIT) & ~mult_done
                  & (r_wcnt == TW'(TIMEOUT - 1));

  mult_operand_counter #(.WIDTH(WIDTH)) u_cnt (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (w_go_acc),
    .i_step  (w_step),
    .o_a     (w_a),
    .o_b     (w_b),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_tmo   <= 1'b0;
      r_pc    <= '0;
      r_wcnt  <= '0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            r_state <= ST_ISSUE;
            r_busy  <= 1'b1;
            r_fin   <= 1'b0;
            r_tmo   <= 1'b0;
            r_pc    <= '0;
          end
        end
        ST_ISSUE: begin
          if (mult_ready) begin
            r_start <= 1'b1;
            r_wcnt  <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_cmp) begin
            r_state <= ST_NEXT;
          end else if (w_expire) begin
            r_tmo   <= 1'b1;
            r_state <= ST_NEXT;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        ST_NEXT: begin
          r_pc <= r_pc + 1'b1;
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_fin   <= 1'b1;
          end else begin
            r_state <= ST_ISSUE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MULT_SWEEP_CHECK_EN
  logic [2*WIDTH-1:0] w_expect;
  logic               w_err_evt;
  logic [15:0]        r_err;

  assign w_expect  = (2*WIDTH)'(w_a) * (2*WIDTH)'(w_b);
  assign w_err_evt = (w_cmp & (mult_product != w_expect)) | w_expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_err <= '0;
    else if (w_go_acc)
      r_err <= '0;
    else if (w_err_evt && r_err != 16'hFFFF)
      r_err <= r_err + 1'b1;
  end

  assign err_count = r_err;
`else
  logic w_unused_product;
  assign w_unused_product = ^mult_product;
  assign err_count = '0;
`endif

  assign mult_start        = r_start;
  assign mult_multiplicand = w_a;
  assign mult_multiplier   = w_b;
  assign busy              = r_busy;
  assign finished          = r_fin;
  assign pair_count        = r_pc;
  assign timeout_err       = r_tmo;

endmodule

// File: tb/tb_mult_sweep_driver.sv
// Directed and randomized sweep checks against a behavioural multiplier model.
module tb_mult_sweep_driver;

  localparam int W  = 2;
  localparam int TO = 8;
  localparam int NP = 1 << (2 * W);
`ifdef MULT_SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic           go;
  logic           mult_ready;
  logic           mult_done;
  logic [2*W-1:0] mult_product;
  logic           mult_start;
  logic [W-1:0]   mult_multiplicand;
  logic [W-1:0]   mult_multiplier;
  logic           busy;
  logic           finished;
  logic [2*W:0]   pair_count;
  logic [15:0]    err_count;
  logic           timeout_err;

  int checks = 0;
  int failures = 0;

  int       rdy_mode = 1;
  logic     rdy_rand = 1'b1;
  bit       skip_en = 1'b0;
  bit       cor_en = 1'b0;
  int       skip_a, skip_b, cor_a, cor_b;
  logic [W-1:0]   la, lb;
  logic           d1, d2;
  logic [2*W-1:0] seen_q[$];

  mult_sweep_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .go                (go),
    .mult_ready        (mult_ready),
    .mult_done         (mult_done),
    .mult_product      (mult_product),
    .mult_start        (mult_start),
    .mult_multiplicand (mult_multiplicand),
    .mult_multiplier   (mult_multiplier),
    .busy              (busy),
    .finished          (finished),
    .pair_count        (pair_count),
    .err_count         (err_count),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  assign mult_ready = (rdy_mode == 1) ? 1'b1 :
                      (rdy_mode == 0) ? 1'b0 : rdy_rand;

  always @(negedge clk) rdy_rand = ($urandom % 4) != 0;

  // Multiplier model: done three cycles after start, optional fault pairs.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
      mult_done <= 1'b0;
      mult_product <= '0;
      la <= '0;
      lb <= '0;
    end else begin
      if (mult_start) begin
        la <= mult_multiplicand;
        lb <= mult_multiplier;
      end
      d1 <= mult_start && !(skip_en && int'(mult_multiplicand) == skip_a
                            && int'(mult_multiplier) == skip_b);
      d2 <= d1;
      mult_done <= d2;
      mult_product <= (2*W)'(int'(la) * int'(lb)
                      + ((cor_en && int'(la) == cor_a && int'(lb) == cor_b) ? 1 : 0));
    end
  end

  always @(posedge clk)
    if (reset_n && mult_start)
      seen_q.push_back({mult_multiplicand, mult_multiplier});

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic wait_finished(string tag);
    int n = 0;
    while (!finished && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_finish_wait"}, 32'(finished), 32'd1);
  endtask

  function automatic int exp_errs();
    int n = 0;
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        if ((skip_en && a == skip_a && b == skip_b) ||
            (cor_en && a == cor_a && b == cor_b))
          n++;
    return CHK ? n : 0;
  endfunction

  task automatic check_sweep(string tag);
    int bad = 0;
    int idx = 0;
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++) begin
        if (idx >= seen_q.size() || seen_q[idx] !== (2*W)'(a * (1 << W) + b))
          bad++;
        idx++;
      end
    chk({tag, "_starts"}, 32'(seen_q.size()), 32'(NP));
    chk({tag, "_order_bad"}, 32'(bad), 32'd0);
    chk({tag, "_pair_count"}, 32'(pair_count), 32'(NP));
    chk({tag, "_err_count"}, 32'(err_count), 32'(exp_errs()));
    chk({tag, "_timeout"}, 32'(timeout_err), 32'(skip_en));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int hits;
    reset_n = 1'b0;
    go = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fin", 32'(finished), 32'd0);
    chk("rst_start", 32'(mult_start), 32'd0);
    chk("rst_pc", 32'(pair_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_ops", 32'({mult_multiplicand, mult_multiplier}), 32'd0);

    // go on the very first edge after reset release
    seen_q.delete();
    reset_n = 1'b1;
    go = 1'b1;
    @(posedge clk);
    #1;
    chk("first_go_busy", 32'(busy), 32'd1);
    @(negedge clk) go = 1'b0;
    wait_finished("ideal");
    check_sweep("ideal");

    cor_en = 1'b1; cor_a = 3; cor_b = 2;
    seen_q.delete();
    pulse_go();
    wait_finished("corrupt");
    check_sweep("corrupt");
    cor_en = 1'b0;

    skip_en = 1'b1; skip_a = 1; skip_b = 1;
    seen_q.delete();
    pulse_go();
    wait_finished("skip");
    check_sweep("skip");
    skip_en = 1'b0;

    // ready held low after go
    rdy_mode = 0;
    seen_q.delete();
    pulse_go();
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mult_start || !busy || mult_multiplicand != 0 || mult_multiplier != 0)
        hits++;
    end
    chk("rdy_low_hold", 32'(hits), 32'd0);
    @(negedge clk) rdy_mode = 1;
    @(posedge clk);
    #1;
    chk("rdy_rise_start", 32'(mult_start), 32'd1);
    wait_finished("rdy");
    check_sweep("rdy");

    // reset during WAIT of (2,1)
    seen_q.delete();
    pulse_go();
    n = 0;
    while (!(mult_start && mult_multiplicand == 2 && mult_multiplier == 1) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_2_1", 32'(n < 500), 32'd1);
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", 32'(pair_count), 32'd0);
    chk("mid_rst_ops", 32'({mult_multiplicand, mult_multiplier}), 32'd0);
    hits = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (mult_start) hits++;
    end
    chk("mid_rst_nostart", 32'(hits), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    seen_q.delete();
    pulse_go();
    wait_finished("after_rst");
    check_sweep("after_rst");

    // go in WAIT ignored, go in DONE restarts
    seen_q.delete();
    pulse_go();
    n = 0;
    while (!mult_start && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    pulse_go();
    wait_finished("go_wait");
    check_sweep("go_wait");
    seen_q.delete();
    @(negedge clk) go = 1'b1;
    @(posedge clk);
    #1;
    chk("done_go_fin", 32'(finished), 32'd0);
    chk("done_go_busy", 32'(busy), 32'd1);
    chk("done_go_pc", 32'(pair_count), 32'd0);
    @(negedge clk) go = 1'b0;
    wait_finished("restart");
    check_sweep("restart");

    // randomized fault pairs with jittery ready
    rdy_mode = 2;
    for (int it = 0; it < 4; it++) begin
      skip_en = 1'($urandom % 2);
      skip_a = int'($urandom % 4);
      skip_b = int'($urandom % 4);
      cor_en = 1'b1;
      cor_a = int'($urandom % 4);
      cor_b = int'($urandom % 4);
      seen_q.delete();
      pulse_go();
      wait_finished("rand");
      check_sweep("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
